// File: rtl/joy_md6_scheduler.sv
// Megadrive 6-button poll sequencer: steps the select line through 8 phases, requests one
// decoder scan per phase, and commits merged per-port button words once per poll.
module joy_md6_scheduler #(
  parameter int unsigned POLL_DIV = 60000,
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        md_select,
  output logic        scan_req,
  input  logic        scan_done,
  input  logic [15:0] scan_data,
  output logic [11:0] joy1_btn,
  output logic [11:0] joy2_btn,
  output logic        joy1_md,
  output logic        joy2_md,
  output logic        joy1_six,
  output logic        joy2_six,
  output logic        frame_strobe,
  output logic        timeout_err
);

  localparam int unsigned DIV_W = $clog2(POLL_DIV + 1);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  // Shadow layout: [11:0] buttons, [12] md pad, [13] six-button pad.
  localparam logic [13:0] SH_RST = 14'h0FFF;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_CAPTURE, S_COMMIT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [11:0]      data_q, data_d;
  logic [13:0]      sh1_q, sh1_d, sh2_q, sh2_d;
  logic             md_select_q, md_select_d, scan_req_q, scan_req_d;
  logic [11:0]      joy1_btn_q, joy1_btn_d, joy2_btn_q, joy2_btn_d;
  logic             joy1_md_q, joy1_md_d, joy2_md_q, joy2_md_d;
  logic             joy1_six_q, joy1_six_d, joy2_six_q, joy2_six_d;
  logic             frame_strobe_q, frame_strobe_d, timeout_err_q, timeout_err_d;
  logic             abort_s;
  logic [13:0]      fin1_s, fin2_s;
  logic             unused_s;

  // pins = {pin1,pin2,pin3,pin4,pin6,pin9} of one port for the given phase.
  function automatic logic [13:0] capture_phase(input logic [2:0] p, input logic [5:0] pins,
                                                input logic [13:0] sh);
    logic [13:0] r;
    r = sh;
    case (p)
      3'd0: begin
        r[0] = pins[5]; r[1] = pins[4]; r[2] = pins[3]; r[3] = pins[2];
        r[4] = pins[1]; r[5] = pins[0];
      end
      3'd1: begin
        r[12] = (pins[3:2] == 2'b00); r[6] = pins[1]; r[7] = pins[0];
      end
      3'd5: r[13] = (pins[5:2] == 4'b0000);
      3'd6: begin
        r[8] = pins[5]; r[9] = pins[4]; r[10] = pins[3]; r[11] = pins[2];
      end
      default: r = sh;
    endcase
    return r;
  endfunction

  // Buttons a pad type cannot report are forced released.
  function automatic logic [13:0] finalize(input logic [13:0] sh);
    logic [13:0] r;
    r = sh;
    if (!sh[12]) begin
      r[11:6] = 6'h3F;
      r[13]   = 1'b0;
    end else if (!sh[13]) begin
      r[11:8] = 4'hF;
    end else begin
      r = sh;
    end
    return r;
  endfunction

  assign abort_s  = (state_q == S_REQ) && !scan_done && (tmo_q == TMO_LAST);
  assign fin1_s   = finalize(sh1_q);
  assign fin2_s   = finalize(sh2_q);
  assign unused_s = ^{scan_data[9:8], scan_data[1:0]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;   phase_q <= 3'd0;    div_q <= '0;      set_q <= '0;
      tmo_q   <= '0;       data_q  <= 12'h000; sh1_q <= SH_RST;  sh2_q <= SH_RST;
    end else begin
      state_q <= state_d;  phase_q <= phase_d; div_q <= div_d;   set_q <= set_d;
      tmo_q   <= tmo_d;    data_q  <= data_d;  sh1_q <= sh1_d;   sh2_q <= sh2_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q; phase_d = phase_q; div_d = div_q; set_d = set_q;
    tmo_d   = tmo_q;   data_d  = data_q;  sh1_d = sh1_q; sh2_d = sh2_q;
    case (state_q)
      S_IDLE: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else if (enable) begin
          state_d = S_SETUP; phase_d = 3'd0; set_d = '0;
          sh1_d   = SH_RST;  sh2_d   = SH_RST;
        end else begin
          div_d = div_q;
        end
      end
      S_SETUP: begin
        if (set_q == SET_LAST) begin
          state_d = S_REQ; tmo_d = '0;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_REQ: begin
        if (scan_done) begin
          data_d  = {scan_data[15:10], scan_data[7:2]};
          state_d = S_CAPTURE;
        end else if (abort_s) begin
          state_d = S_IDLE; div_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CAPTURE: begin
        sh1_d = capture_phase(phase_q, data_q[5:0], sh1_q);
        sh2_d = capture_phase(phase_q, data_q[11:6], sh2_q);
        if (phase_q == 3'd7) begin
          state_d = S_COMMIT;
        end else begin
          phase_d = phase_q + 3'd1; set_d = '0; state_d = S_SETUP;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE; div_d = '0;
      end
      default: begin
        state_d = S_IDLE; div_d = '0;
      end
    endcase
  end

  // Output next values; select only moves on SETUP entry or when leaving the poll.
  always_comb begin
    md_select_d    = 1'b1;
    scan_req_d     = (state_d == S_REQ);
    frame_strobe_d = (state_q == S_COMMIT);
    joy1_btn_d = joy1_btn_q; joy1_md_d = joy1_md_q; joy1_six_d = joy1_six_q;
    joy2_btn_d = joy2_btn_q; joy2_md_d = joy2_md_q; joy2_six_d = joy2_six_q;
    timeout_err_d = timeout_err_q;
    if ((state_d == S_SETUP) || (state_d == S_REQ) || (state_d == S_CAPTURE)) begin
      md_select_d = ~phase_d[0];
    end else begin
      md_select_d = 1'b1;
    end
    if (state_q == S_COMMIT) begin
      joy1_btn_d = fin1_s[11:0]; joy1_md_d = fin1_s[12]; joy1_six_d = fin1_s[13];
      joy2_btn_d = fin2_s[11:0]; joy2_md_d = fin2_s[12]; joy2_six_d = fin2_s[13];
      timeout_err_d = 1'b0;
    end else if (abort_s) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_select_q <= 1'b1;    scan_req_q <= 1'b0;  frame_strobe_q <= 1'b0; timeout_err_q <= 1'b0;
      joy1_btn_q  <= 12'hFFF; joy1_md_q  <= 1'b0;  joy1_six_q <= 1'b0;
      joy2_btn_q  <= 12'hFFF; joy2_md_q  <= 1'b0;  joy2_six_q <= 1'b0;
    end else begin
      md_select_q <= md_select_d; scan_req_q <= scan_req_d;
      frame_strobe_q <= frame_strobe_d; timeout_err_q <= timeout_err_d;
      joy1_btn_q <= joy1_btn_d; joy1_md_q <= joy1_md_d; joy1_six_q <= joy1_six_d;
      joy2_btn_q <= joy2_btn_d; joy2_md_q <= joy2_md_d; joy2_six_q <= joy2_six_d;
    end
  end

  assign md_select    = md_select_q;
  assign scan_req     = scan_req_q;
  assign frame_strobe = frame_strobe_q;
  assign timeout_err  = timeout_err_q;
  assign joy1_btn     = joy1_btn_q;
  assign joy2_btn     = joy2_btn_q;
  assign joy1_md      = joy1_md_q;
  assign joy2_md      = joy2_md_q;
  assign joy1_six     = joy1_six_q;
  assign joy2_six     = joy2_six_q;

endmodule

// File: tb/tb_joy_md6_scheduler.sv
// Directed bench for joy_md6_scheduler: a pad responder answers each scan request from a
// table of per-phase bytes and the committed words are compared with hand-computed values.
module tb_joy_md6_scheduler;

  localparam int P_DIV = 20;
  localparam int P_SET = 3;
  localparam int P_TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n, enable, scan_done;
  logic [15:0] scan_data;
  logic        md_select, scan_req, frame_strobe, timeout_err;
  logic [11:0] joy1_btn, joy2_btn;
  logic        joy1_md, joy2_md, joy1_six, joy2_six;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0][15:0] d;
    logic [11:0]      b1;
    logic [11:0]      b2;
    logic             m1, m2, s1, s2;
  } vec_t;

  vec_t tbl [5];

  joy_md6_scheduler #(.POLL_DIV(P_DIV), .SETTLE(P_SET), .TIMEOUT(P_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .md_select(md_select), .scan_req(scan_req),
    .scan_done(scan_done), .scan_data(scan_data),
    .joy1_btn(joy1_btn), .joy2_btn(joy2_btn),
    .joy1_md(joy1_md), .joy2_md(joy2_md),
    .joy1_six(joy1_six), .joy2_six(joy2_six),
    .frame_strobe(frame_strobe), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 300; i++) begin
      if (scan_req) break;
      @(negedge clk);
    end
    chk("scan_req_seen", {15'd0, scan_req}, 16'd1);
  endtask

  task automatic check_commit(input vec_t v);
    for (int i = 0; i < 100; i++) begin
      if (frame_strobe) break;
      @(negedge clk);
    end
    chk("frame_strobe", {15'd0, frame_strobe}, 16'd1);
    chk("joy1_btn", {4'd0, joy1_btn}, {4'd0, v.b1});
    chk("joy2_btn", {4'd0, joy2_btn}, {4'd0, v.b2});
    chk("joy_md",  {14'd0, joy2_md, joy1_md},   {14'd0, v.m2, v.m1});
    chk("joy_six", {14'd0, joy2_six, joy1_six}, {14'd0, v.s2, v.s1});
    chk("timeout_err_clr", {15'd0, timeout_err}, 16'd0);
    @(negedge clk);
    chk("strobe_one_cycle", {15'd0, frame_strobe}, 16'd0);
  endtask

  // Answers all eight phases; optional stray scan_done, enable drop, or early stop.
  task automatic run_poll(input vec_t v, input int glitch_ph, input int drop_en_ph,
                          input int stop_ph);
    for (int p = 0; p < 8; p++) begin
      wait_req();
      chk($sformatf("md_select_p%0d", p), {15'd0, md_select},
          (p % 2 == 0) ? 16'd1 : 16'd0);
      if (p == stop_ph) return;
      if (p == drop_en_ph) enable = 1'b0;
      @(negedge clk);
      scan_data = v.d[p];
      scan_done = 1'b1;
      @(negedge clk);
      scan_done = 1'b0;
      scan_data = 16'h0000;
      chk("req_dropped", {15'd0, scan_req}, 16'd0);
      if (p == glitch_ph) begin
        @(negedge clk);
        scan_data = 16'h0000;
        scan_done = 1'b1;
        @(negedge clk);
        scan_done = 1'b0;
        chk("setup_done_ignored", {15'd0, scan_req}, 16'd0);
      end
    end
    check_commit(v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    int sel_lo_cnt;

    for (int i = 0; i < 5; i++) tbl[i].d = {8{16'hFCFC}};
    tbl[0].b1 = 12'hFFF; tbl[0].b2 = 12'hFFF;
    {tbl[0].m1, tbl[0].m2, tbl[0].s1, tbl[0].s2} = 4'b0000;
    // 3-button pad on port 1, junk in discarded phases
    tbl[1].d[1] = 16'hFC44;
    tbl[1].d[2] = 16'h0000; tbl[1].d[3] = 16'h0000;
    tbl[1].d[4] = 16'h0000; tbl[1].d[7] = 16'h0000;
    tbl[1].b1 = 12'hFBF; tbl[1].b2 = 12'hFFF;
    {tbl[1].m1, tbl[1].m2, tbl[1].s1, tbl[1].s2} = 4'b1000;
    // 6-button all pressed on port 1; port 2 not MD with six-looking bytes
    for (int p = 0; p < 8; p++) tbl[2].d[p] = 16'hFC00;
    tbl[2].d[5] = 16'h0000; tbl[2].d[6] = 16'h0000;
    tbl[2].b1 = 12'h000; tbl[2].b2 = 12'hFFF;
    {tbl[2].m1, tbl[2].m2, tbl[2].s1, tbl[2].s2} = 4'b1010;
    // 3-button pad on port 1 with xyz bits pressed but forced released
    tbl[3].d[0] = 16'hFCA8; tbl[3].d[1] = 16'hFC08; tbl[3].d[6] = 16'hFC00;
    tbl[3].b1 = 12'hF55; tbl[3].b2 = 12'hFFF;
    {tbl[3].m1, tbl[3].m2, tbl[3].s1, tbl[3].s2} = 4'b1000;
    // 6-button pad on port 2 with Z pressed
    tbl[4].d[1] = 16'h0CFC; tbl[4].d[5] = 16'h0CFC; tbl[4].d[6] = 16'h7CFC;
    tbl[4].b1 = 12'hFFF; tbl[4].b2 = 12'hEFF;
    {tbl[4].m1, tbl[4].m2, tbl[4].s1, tbl[4].s2} = 4'b0101;

    rst_n = 1'b0; enable = 1'b1; scan_done = 1'b0; scan_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_md_select", {15'd0, md_select}, 16'd1);
    chk("rst_scan_req", {15'd0, scan_req}, 16'd0);
    chk("rst_btn", {joy2_btn[3:0], joy1_btn}, 16'hFFFF);
    chk("rst_flags", {10'd0, joy1_md, joy2_md, joy1_six, joy2_six, frame_strobe, timeout_err},
        16'd0);
    rst_n = 1'b1;

    // First poll with no decoder answer: exact request latency, then timeout abort.
    repeat (P_DIV + P_SET) @(posedge clk);
    #1 chk("req_not_yet", {15'd0, scan_req}, 16'd0);
    @(posedge clk);
    #1 chk("req_latency", {15'd0, scan_req}, 16'd1);
    chk("req_md_select", {15'd0, md_select}, 16'd1);
    repeat (P_TMO - 1) @(posedge clk);
    #1 chk("req_still_waiting", {14'd0, scan_req, timeout_err}, 16'd2);
    @(posedge clk);
    #1 chk("timeout_err", {15'd0, timeout_err}, 16'd1);
    chk("timeout_req_drop", {15'd0, scan_req}, 16'd0);
    chk("timeout_md_select", {15'd0, md_select}, 16'd1);
    chk("timeout_btn", {4'd0, joy1_btn}, 16'h0FFF);
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_poll(tbl[i], -1, -1, -1);

    // Stray scan_done in p1 SETUP must not advance the sequence.
    run_poll(tbl[3], 0, -1, -1);

    // Enable drops during p3: poll still commits, then no further polls.
    run_poll(tbl[4], -1, 3, -1);
    req_cnt = 0;
    sel_lo_cnt = 0;
    for (int i = 0; i < 3 * P_DIV; i++) begin
      @(negedge clk);
      if (scan_req) req_cnt++;
      if (!md_select) sel_lo_cnt++;
    end
    chk("disabled_no_req", req_cnt[15:0], 16'd0);
    chk("disabled_sel_high", sel_lo_cnt[15:0], 16'd0);
    enable = 1'b1;

    // Asynchronous reset while p4 waits for the decoder.
    run_poll(tbl[1], -1, -1, 4);
    #2 rst_n = 1'b0;
    #1 chk("arst_scan_req", {15'd0, scan_req}, 16'd0);
    chk("arst_md_select", {15'd0, md_select}, 16'd1);
    chk("arst_joy2_btn", {4'd0, joy2_btn}, 16'h0FFF);
    chk("arst_joy2_flags", {14'd0, joy2_md, joy2_six}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/joy_md6_scheduler.md
# joy_md6_scheduler

Poll sequencer for the serial DB9 joystick interface. Drives the shared Megadrive select line through the 8-phase 6-button protocol and requests one 16-bit shift-register scan per phase from the joystick decoder. It merges the phases into per-port 12-button words plus pad-type flags, and commits them atomically once per poll. It sits between the decoder (below) and the keyboard/joystick mapping logic (above).

## Interface
- POLL_DIV, 60000: clk cycles of idle (select high) between the commit and the next poll start; must be ≥ 2.
- SETTLE, 8: clk cycles from a select change to scan_req assertion; must be ≥ 1.
- TIMEOUT, 4096: max clk cycles scan_req may wait for scan_done.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  allow new polls; sampled only in IDLE
- md_select  out  1  Megadrive select line to both ports (decoder joy_latch_megadrive)
- scan_req  out  1  request one decoder scan; level, held until scan_done
- scan_done  in  1  one-cycle pulse; scan_data valid in the same cycle
- scan_data  in  16  raw active-low pins: [15:8] port 2, [7:0] port 1; per byte [7]=pin1 [6]=pin2 [5]=pin3 [4]=pin4 [3]=pin6 [2]=pin9, [1:0] ignored
- joy1_btn, joy2_btn  out  12  active-low {mode,x,y,z,start,a,c,b,right,left,down,up}
- joy1_md, joy2_md  out  1  Megadrive pad detected
- joy1_six, joy2_six  out  1  6-button pad detected
- frame_strobe  out  1  one-cycle pulse on every successful commit
- timeout_err  out  1  last poll aborted on timeout

## Operation
- States: IDLE, SETUP, REQ, CAPTURE, COMMIT.
- IDLE: md_select=1. The divider counts up to POLL_DIV. When it expires and enable=1: phase p:=0, go to SETUP. With enable=0 the FSM holds and the divider saturates.
- SETUP: md_select = ~p[0] (p0 high, p1 low, … p7 low). Wait SETTLE cycles, then go to REQ.
- REQ: scan_req=1 and the timeout counter runs. scan_done → latch scan_data, drop scan_req the next cycle, go to CAPTURE. Counter reaching TIMEOUT → abort: scan_req=0, md_select=1, timeout_err=1, shadows discarded, go to IDLE with the divider cleared.
- CAPTURE, per port independently, using byte d:
  - p0: up,down,left,right = d[7:4]; b=d[3]; c=d[2].
  - p1: md_shadow = (d[5]==0 && d[4]==0); a=d[3]; start=d[2].
  - p5: six_shadow = (d[7:4]==4'b0000).
  - p6: z,y,x,mode = d[7],d[6],d[5],d[4].
  - All other phases: discard.
  - Then if p==7 go to COMMIT; else p:=p+1 and go to SETUP.
- COMMIT, per port:
  - if !md_shadow: force a, start, six and x, y, z, mode to 1/0 released values (btn bits 11:6 = 1, six=0).
  - if md_shadow && !six_shadow: force x, y, z, mode = 1.
  - Update all outputs in the same cycle, pulse frame_strobe, clear timeout_err, go to IDLE with md_select=1.
- scan_done outside REQ is ignored.
- enable falling mid-poll does not abort; the current poll completes.

## Timing
- Reset values: md_select=1, scan_req=0, joyN_btn=12'hFFF, joyN_md=0, joyN_six=0, frame_strobe=0, timeout_err=0, state=IDLE, divider=0.
- Reset is asynchronous and may occur mid-poll. scan_req drops and md_select rises immediately.
- Per-phase cost: 1 (SETUP entry) + SETTLE + handshake wait + 1 (CAPTURE) cycles.
- scan_req rises exactly SETTLE cycles after md_select changes.
- md_select never changes while scan_req=1.
- Outputs change only in the COMMIT cycle; frame_strobe is high in that cycle.
- md_select stays high for ≥ POLL_DIV cycles between polls, which resets the pad's 6-button counter.

## Test plan
- Reset, then hold scan_done=0 → after POLL_DIV+1+SETTLE cycles scan_req=1 and md_select=1; after TIMEOUT cycles timeout_err=1, scan_req=0, joy1_btn=12'hFFF.
- Pad model answering all phases with 8'hFC (plain stick, nothing pressed) → commit gives joy1_btn=12'hFFF, joy1_md=0, joy1_six=0, one frame_strobe.
- 3-button MD pad: p1 byte 8'h44 (A pressed, start released), others 8'hFC → joy1_btn bit a=0, joy1_md=1, joy1_six=0, bits 11:8=4'hF.
- 6-button pad on port 2: p5 byte 8'h0C, p6 byte 8'h7C (Z pressed) → joy2_six=1, joy2_btn[8]=0; port 1 independent and unchanged.
- Check md_select sequence 1,0,1,0,1,0,1,0 across the 8 scan_req assertions; scan_done pulsed during SETUP is ignored; enable=0 during p3 still yields a commit, then no new scan_req.
- Assert rst_n low during p4 REQ → same cycle scan_req=0, md_select=1; outputs return to reset values.
